mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the address and data width.
REQ-002 SHALL have parameter MAX_BURST, default 8, meaning the maximum number of consecutive locked transfers per grant (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports m0_req_i / m1_req_i  input  1  master 0 (core) / master 1 (DMA/blitter) transfer request.
REQ-006 SHALL have ports m0_we_i / m1_we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports m0_addr_i / m1_addr_i  input  WIDTH  transfer address.
REQ-008 SHALL have ports m0_wdata_i / m1_wdata_i  input  WIDTH  write data.
REQ-009 SHALL have port m1_lock_i  input  1  master 1 burst lock.
REQ-010 SHALL have ports m0_gnt_o / m1_gnt_o  output  1  transfer accepted this cycle.
REQ-011 SHALL have ports m0_rvalid_o / m1_rvalid_o  output  1  read data valid.
REQ-012 SHALL have ports m0_rdata_o / m1_rdata_o  output  WIDTH  read data.
REQ-013 SHALL have ports memread_o, memwrite_o  output  1  memory strobes.
REQ-014 SHALL have ports memaddr_o, memwdata_o  output  WIDTH  memory address and write data.
REQ-015 SHALL have port memrdata_i  input  WIDTH  memory read data, valid one cycle after memread_o.

Function
REQ-016 SHALL implement states IDLE, OWN0 and OWN1; gnt of master x is high iff state==OWNx and mx_req_i is high.
REQ-017 SHALL arbitrate in IDLE and after every completed transfer. Winner: requesting master; if both request, see REQ-030. If neither requests, next state is IDLE.
REQ-018 SHALL assert the first grant exactly one cycle after a request is seen in IDLE.
REQ-019 SHALL sustain one transfer per cycle for back-to-back requests, with no IDLE bubble.
REQ-020 SHALL drive memread_o = gnt & !we and memwrite_o = gnt & we combinationally from the owner's inputs; memaddr_o and memwdata_o SHALL be driven from the owner's inputs.
REQ-021 SHALL drive memread_o, memwrite_o, memaddr_o and memwdata_o to 0 when no grant is high.
REQ-022 SHALL, for a read granted in cycle N, pulse the owner's rvalid_o in cycle N+1 with rdata_o = memrdata_i registered. rdata_o SHALL hold its value otherwise.
REQ-023 SHALL treat a request as consumed in any cycle with req & gnt high. Masters hold req, we, addr and wdata stable until granted. Dropping req before grant cancels it without effect.
REQ-024 SHALL keep OWN1 while m1_lock_i & m1_req_i are high, counting transfers in an 8-bit burst counter.
REQ-025 SHALL force re-arbitration when the burst counter reaches MAX_BURST, giving master 0 precedence if it requests, then clear the counter.
REQ-026 SHALL clear the burst counter on any ownership change or when lock drops.
REQ-027 SHALL never assert both grants in one cycle.
REQ-028 SHALL never allow both rvalid outputs high in one cycle.

Reset
REQ-029 SHALL, while rst is low, force the following immediately and asynchronously: state=IDLE, both gnt=0, both rvalid=0, both rdata=0, all mem outputs=0, burst counter=0, last-served pointer=1 (master 0 favoured first). A read granted in the cycle before reset assertion SHALL produce no rvalid.

Configuration
REQ-030 SHALL use macro MEM_ARB_RR_EN. When defined, simultaneous requests are resolved round-robin: the master not last served wins, and the pointer updates on every grant. When undefined, master 0 always wins ties and the pointer logic is absent. Lock and MAX_BURST behaviour SHALL be identical in both builds.

Verification
REQ-031 Bench SHALL cover: single read. m0 read addr 0x10 in IDLE. Required: m0_gnt_o high at cycle +1, memread_o=1 with memaddr_o=0x10, m0_rvalid_o at +2 carrying memrdata_i (e.g. 0xDEADBEEF).
REQ-032 Bench SHALL cover: contention with MEM_ARB_RR_EN defined. Both masters request continuously after reset. Required: grants alternate m0, m1, m0, m1 with one transfer per cycle. With the macro undefined, m0 is granted every cycle.
REQ-033 Bench SHALL cover: locked burst, MAX_BURST=4. m1 lock+req for 10 transfers while m0 requests. Required: 4 m1 grants, then 1 m0 grant, then m1 resumes.
REQ-034 Bench SHALL cover: write. m1 write 0x55AA to addr 0x20. Required: memwrite_o=1, memaddr_o=0x20, memwdata_o=0x55AA for exactly one cycle, and no rvalid.
REQ-035 Bench SHALL cover: reset mid-read. Assert rst low one cycle after an m0 read grant. Required: all outputs 0 immediately, no rvalid, and the first post-reset tie goes to m0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the two master request ports and the memory port.
// slave  - the arbiter's view (takes requests, drives grants and memory strobes).
// master - the environment's view (masters plus memory).
interface mem_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             m0_req_i;
  logic             m1_req_i;
  logic             m0_we_i;
  logic             m1_we_i;
  logic [WIDTH-1:0] m0_addr_i;
  logic [WIDTH-1:0] m1_addr_i;
  logic [WIDTH-1:0] m0_wdata_i;
  logic [WIDTH-1:0] m1_wdata_i;
  logic             m1_lock_i;
  logic             m0_gnt_o;
  logic             m1_gnt_o;
  logic             m0_rvalid_o;
  logic             m1_rvalid_o;
  logic [WIDTH-1:0] m0_rdata_o;
  logic [WIDTH-1:0] m1_rdata_o;
  logic             memread_o;
  logic             memwrite_o;
  logic [WIDTH-1:0] memaddr_o;
  logic [WIDTH-1:0] memwdata_o;
  logic [WIDTH-1:0] memrdata_i;

  modport slave (
    input  m0_req_i, m1_req_i, m0_we_i, m1_we_i, m0_addr_i, m1_addr_i,
    input  m0_wdata_i, m1_wdata_i, m1_lock_i, memrdata_i,
    output m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o,
    output memread_o, memwrite_o, memaddr_o, memwdata_o
  );

  modport master (
    output m0_req_i, m1_req_i, m0_we_i, m1_we_i, m0_addr_i, m1_addr_i,
    output m0_wdata_i, m1_wdata_i, m1_lock_i, memrdata_i,
    input  m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o,
    input  memread_o, memwrite_o, memaddr_o, memwdata_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of a single-port synchronous memory.
// Master 0 is the core, master 1 a DMA/blitter that may lock the bus for bursts of
// up to MAX_BURST transfers, after which the core gets precedence.
// Optional feature: define MEM_ARB_RR_EN to resolve simultaneous requests round-robin;
// without it master 0 wins every tie and no last-served pointer exists.
module mem_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave io_bus
);

  localparam logic [7:0] BurstMax = 8'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [7:0]       r_burst;
  logic [7:0]       w_burst_next;
  logic [7:0]       w_burst_inc;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_tie_m0;
  logic             r_rvalid0;
  logic             r_rvalid1;
  logic [WIDTH-1:0] r_rdata0;
  logic [WIDTH-1:0] r_rdata1;

  // A grant is simply "owner is still requesting"; a dropped request is a cancel.
  assign w_gnt0 = (r_state == StOwn0) & io_bus.m0_req_i;
  assign w_gnt1 = (r_state == StOwn1) & io_bus.m1_req_i;

`ifdef MEM_ARB_RR_EN
  logic r_last;  // 1 = master 1 served most recently
  logic w_last;

  // The grant of this cycle already counts as "last served" for the next decision.
  assign w_last   = w_gnt0 ? 1'b0 : (w_gnt1 ? 1'b1 : r_last);
  assign w_tie_m0 = w_last;

  // Last-served pointer, reset so master 0 wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_last <= 1'b1;
    else      r_last <= w_last;
  end
`else
  assign w_tie_m0 = 1'b1;
`endif

  // Ownership register and burst counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_burst <= '0;
    end else begin
      r_state <= w_state_next;
      r_burst <= w_burst_next;
    end
  end

  // Next owner: arbitrate every cycle unless a locked burst is still below its limit
  always_comb begin
    w_burst_inc  = r_burst + 8'd1;
    w_burst_next = '0;
    if (io_bus.m0_req_i && (!io_bus.m1_req_i || w_tie_m0)) begin
      w_state_next = StOwn0;
    end else if (io_bus.m1_req_i) begin
      w_state_next = StOwn1;
    end else begin
      w_state_next = StIdle;
    end
    if (w_gnt1 && io_bus.m1_lock_i) begin
      if (w_burst_inc != BurstMax) begin
        w_state_next = StOwn1;
        w_burst_next = w_burst_inc;
      end else begin
        // Burst limit: core first if it is waiting; m1 is known to be requesting
        w_state_next = io_bus.m0_req_i ? StOwn0 : StOwn1;
      end
    end
  end

  // Memory strobes and bus mux from the granted master, all zero otherwise
  always_comb begin
    io_bus.memread_o  = 1'b0;
    io_bus.memwrite_o = 1'b0;
    io_bus.memaddr_o  = '0;
    io_bus.memwdata_o = '0;
    if (w_gnt0) begin
      io_bus.memread_o  = ~io_bus.m0_we_i;
      io_bus.memwrite_o = io_bus.m0_we_i;
      io_bus.memaddr_o  = io_bus.m0_addr_i;
      io_bus.memwdata_o = io_bus.m0_wdata_i;
    end else if (w_gnt1) begin
      io_bus.memread_o  = ~io_bus.m1_we_i;
      io_bus.memwrite_o = io_bus.m1_we_i;
      io_bus.memaddr_o  = io_bus.m1_addr_i;
      io_bus.memwdata_o = io_bus.m1_wdata_i;
    end
  end

  // Read response tracking; the held copy keeps rdata stable between responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~io_bus.m0_we_i;
      r_rvalid1 <= w_gnt1 & ~io_bus.m1_we_i;
      if (r_rvalid0) r_rdata0 <= io_bus.memrdata_i;
      if (r_rvalid1) r_rdata1 <= io_bus.memrdata_i;
    end
  end

  assign io_bus.m0_gnt_o    = w_gnt0;
  assign io_bus.m1_gnt_o    = w_gnt1;
  assign io_bus.m0_rvalid_o = r_rvalid0;
  assign io_bus.m1_rvalid_o = r_rvalid1;
  // Memory data arrives in the rvalid cycle itself, so it is passed through then
  assign io_bus.m0_rdata_o  = r_rvalid0 ? io_bus.memrdata_i : r_rdata0;
  assign io_bus.m1_rdata_o  = r_rvalid1 ? io_bus.memrdata_i : r_rdata1;

endmodule
